// File: rtl/ap_ram_arbiter.sv
// Single-port RAM arbiter: memory-clear sweep, ApLine core port and halted-only front-panel
// debug port. Read data lands in the owner's data_o on the edge that closes the RESP cycle.
module ap_ram_arbiter #(
  parameter int ROWS       = 30000,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_data_i,
  output logic                  core_rdy_o,
  output logic [DATA_WIDTH-1:0] core_data_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_data_i,
  output logic                  dbg_rdy_o,
  output logic [DATA_WIDTH-1:0] dbg_data_o,
  input  logic                  halted_i,
  input  logic                  clr_req_i,
  output logic                  clr_busy_o,
  output logic                  ram_cs_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROWS - 1);
  localparam logic OWN_CORE = 1'b1;
  localparam logic OWN_DBG  = 1'b0;

  state_e                state_q, state_d;
  logic                  own_q, own_d;
  logic                  we_q, we_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cs_q, cs_d;
  logic                  rwe_q, rwe_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  core_rdy_q, core_rdy_d;
  logic                  dbg_rdy_q, dbg_rdy_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] core_dout_q, core_dout_d;
  logic [DATA_WIDTH-1:0] dbg_dout_q, dbg_dout_d;
  logic                  core_ok_s, dbg_ok_s, pick_core_s;

  // Next-state, grant latching and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    core_dout_d = core_dout_q;
    dbg_dout_d  = dbg_dout_q;
    core_ok_s   = core_req_i;
    dbg_ok_s    = dbg_req_i & halted_i;
    // On a tie the port that did not win last time gets the grant
    pick_core_s = core_ok_s & (~dbg_ok_s | (last_q == OWN_DBG));

    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (core_ok_s | dbg_ok_s) begin
          state_d = ACCESS;
          own_d   = pick_core_s ? OWN_CORE : OWN_DBG;
          last_d  = pick_core_s ? OWN_CORE : OWN_DBG;
          we_d    = pick_core_s ? core_we_i : dbg_we_i;
          addr_d  = pick_core_s ? core_addr_i : dbg_addr_i;
          wdata_d = pick_core_s ? core_data_i : dbg_data_i;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (!we_q && own_q == OWN_CORE) begin
          core_dout_d = ram_data_i;
        end else if (!we_q) begin
          dbg_dout_d = ram_data_i;
        end else begin
          core_dout_d = core_dout_q;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cs_d       = (state_d == ACCESS) || (state_d == CLEAR);
    rwe_d      = (state_d == ACCESS) ? we_d : (state_d == CLEAR);
    raddr_d    = (state_d == ACCESS) ? addr_d : ((state_d == CLEAR) ? cnt_d : '0);
    rdata_d    = (state_d == ACCESS) ? wdata_d : '0;
    core_rdy_d = (state_d == RESP) && (own_d == OWN_CORE);
    dbg_rdy_d  = (state_d == RESP) && (own_d == OWN_DBG);
    busy_d     = (state_d == CLEAR);
  end

  // State, latched request, sweep counter and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      own_q       <= OWN_DBG;
      we_q        <= 1'b0;
      last_q      <= OWN_DBG;
      addr_q      <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      cs_q        <= 1'b0;
      rwe_q       <= 1'b0;
      raddr_q     <= '0;
      rdata_q     <= '0;
      core_rdy_q  <= 1'b0;
      dbg_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      core_dout_q <= '0;
      dbg_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      we_q        <= we_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      cs_q        <= cs_d;
      rwe_q       <= rwe_d;
      raddr_q     <= raddr_d;
      rdata_q     <= rdata_d;
      core_rdy_q  <= core_rdy_d;
      dbg_rdy_q   <= dbg_rdy_d;
      busy_q      <= busy_d;
      core_dout_q <= core_dout_d;
      dbg_dout_q  <= dbg_dout_d;
    end
  end

  assign ram_cs_o    = cs_q;
  assign ram_we_o    = rwe_q;
  assign ram_addr_o  = raddr_q;
  assign ram_data_o  = rdata_q;
  assign core_rdy_o  = core_rdy_q;
  assign dbg_rdy_o   = dbg_rdy_q;
  assign clr_busy_o  = busy_q;
  assign core_data_o = core_dout_q;
  assign dbg_data_o  = dbg_dout_q;

endmodule

// File: tb/tb_ap_ram_arbiter.sv
// Bench for ap_ram_arbiter: behavioural RAM, a timeline predictor of the outputs checked every
// cycle, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ap_ram_arbiter;
  localparam int ROWS = 16;
  localparam int AW   = 4;
  localparam int DW   = 12;
  localparam int TABN = 1024;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          core_req_i = 1'b0, core_we_i = 1'b0;
  logic [AW-1:0] core_addr_i = '0;
  logic [DW-1:0] core_data_i = '0;
  logic          core_rdy_o;
  logic [DW-1:0] core_data_o;
  logic          dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [DW-1:0] dbg_data_i = '0;
  logic          dbg_rdy_o;
  logic [DW-1:0] dbg_data_o;
  logic          halted_i = 1'b0, clr_req_i = 1'b0, clr_busy_o;
  logic          ram_cs_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_data_o, ram_data_i;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;

  ap_ram_arbiter #(.ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_data_i(core_data_i), .core_rdy_o(core_rdy_o), .core_data_o(core_data_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_data_i(dbg_data_i), .dbg_rdy_o(dbg_rdy_o), .dbg_data_o(dbg_data_o),
    .halted_i(halted_i), .clr_req_i(clr_req_i), .clr_busy_o(clr_busy_o),
    .ram_cs_o(ram_cs_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // Synchronous single-port RAM, preloaded with 0x100+i
  logic [DW-1:0] mem [ROWS];
  logic [DW-1:0] ram_rd = '0;
  logic          mem_ready = 1'b0;
  assign ram_data_i = ram_rd;
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= DW'(12'h100 + i);
      mem_ready <= 1'b1;
    end else if (ram_cs_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
      else ram_rd <= mem[ram_addr_o];
    end
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: a grant at cycle c owns the RAM at c+1, pulses rdy at c+2,
  // updates data_o at c+3; a clear writes cells 0..ROWS-1 on the ROWS cycles after c.
  typedef struct packed {
    logic          cs, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          crdy, drdy, busy, set_c, set_d;
    logic [DW-1:0] val;
  } exp_t;
  exp_t          tab [TABN];
  logic [DW-1:0] shadow [ROWS];
  logic          sh_init = 1'b0;
  logic [DW-1:0] m_core = '0, m_dbg = '0;
  logic          m_last_core = 1'b0;
  int            free_at = 0;

  always @(negedge Clk) begin
    exp_t          e;
    logic          use_core, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!Rst_n) begin
      if (!sh_init) begin
        for (int i = 0; i < ROWS; i++) shadow[i] = DW'(12'h100 + i);
        sh_init = 1'b1;
      end
      for (int i = 0; i < TABN; i++) tab[i] = '0;
      m_core = '0; m_dbg = '0; m_last_core = 1'b0; free_at = cyc + 1;
      e = '0;
    end else begin
      e = tab[cyc % TABN];
      if (e.set_c) m_core = e.val;
      if (e.set_d) m_dbg = e.val;
    end
    chk("m_cs", ram_cs_o, e.cs);
    chk("m_we", ram_we_o, e.we);
    chk("m_addr", ram_addr_o, e.addr);
    chk("m_wdata", ram_data_o, e.data);
    chk("m_core_rdy", core_rdy_o, e.crdy);
    chk("m_dbg_rdy", dbg_rdy_o, e.drdy);
    chk("m_busy", clr_busy_o, e.busy);
    chk("m_core_data", core_data_o, m_core);
    chk("m_dbg_data", dbg_data_o, m_dbg);
    if (Rst_n) begin
      if (e.cs && e.we) shadow[e.addr] = e.data;
      tab[cyc % TABN] = '0;
      if (cyc >= free_at) begin
        if (clr_req_i) begin
          for (int k = 0; k < ROWS; k++) begin
            tab[(cyc + 1 + k) % TABN].cs   = 1'b1;
            tab[(cyc + 1 + k) % TABN].we   = 1'b1;
            tab[(cyc + 1 + k) % TABN].addr = AW'(k);
            tab[(cyc + 1 + k) % TABN].busy = 1'b1;
          end
          free_at = cyc + 1 + ROWS;
        end else if (core_req_i || (dbg_req_i && halted_i)) begin
          use_core = core_req_i && !(dbg_req_i && halted_i && m_last_core);
          m_last_core = use_core;
          w = use_core ? core_we_i : dbg_we_i;
          a = use_core ? core_addr_i : dbg_addr_i;
          d = use_core ? core_data_i : dbg_data_i;
          tab[(cyc + 1) % TABN].cs   = 1'b1;
          tab[(cyc + 1) % TABN].we   = w;
          tab[(cyc + 1) % TABN].addr = a;
          tab[(cyc + 1) % TABN].data = d;
          tab[(cyc + 2) % TABN].crdy = use_core;
          tab[(cyc + 2) % TABN].drdy = !use_core;
          if (!w) begin
            tab[(cyc + 3) % TABN].set_c = use_core;
            tab[(cyc + 3) % TABN].set_d = !use_core;
            tab[(cyc + 3) % TABN].val   = shadow[a];
          end
          free_at = cyc + 3;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One access on one port, issued in an IDLE cycle, with literal latency checks
  task automatic op(input logic is_dbg, input logic we, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    if (is_dbg) begin
      dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = a; dbg_data_i = d;
    end else begin
      core_req_i = 1'b1; core_we_i = we; core_addr_i = a; core_data_i = d;
    end
    tick();
    chk("op_cs_n1", ram_cs_o, 1);
    chk("op_we_n1", ram_we_o, we);
    chk("op_addr_n1", ram_addr_o, a);
    core_req_i = 1'b0; dbg_req_i = 1'b0;
    core_addr_i = ~a; dbg_addr_i = ~a; core_we_i = ~we; dbg_we_i = ~we;
    tick();
    chk("op_rdy_n2", is_dbg ? dbg_rdy_o : core_rdy_o, 1);
    chk("op_other_rdy_n2", is_dbg ? core_rdy_o : dbg_rdy_o, 0);
    tick();
    chk("op_rdy_n3", is_dbg ? dbg_rdy_o : core_rdy_o, 0);
    if (!we) chk("op_rdata", is_dbg ? dbg_data_o : core_data_o, exp_rd);
  endtask

  initial begin
    int got;
    int nz;
    repeat (2) tick();
    chk("rst_cs", ram_cs_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_busy", clr_busy_o, 0);
    chk("rst_core_data", core_data_o, 0);
    Rst_n = 1'b1;

    // Contention straight after reset: core first, then alternate
    halted_i = 1'b1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 4'd3;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 4'd4;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("cont_core_rdy", core_rdy_o, (t == 2 || t == 8));
      chk("cont_dbg_rdy", dbg_rdy_o, (t == 5 || t == 11));
      if (t == 10) begin core_req_i = 1'b0; dbg_req_i = 1'b0; end
    end
    chk("cont_core_data", core_data_o, 12'h103);
    chk("cont_dbg_data", dbg_data_o, 12'h104);

    // Core write then read back, back-to-back
    op(1'b0, 1'b1, 4'd5, 12'h123, 12'h000);
    op(1'b0, 1'b0, 4'd5, 12'h000, 12'h123);
    chk("wr_rd_core_data", core_data_o, 12'h123);

    // Read isolation between ports
    op(1'b0, 1'b1, 4'd9, 12'h999, 12'h000);
    op(1'b1, 1'b1, 4'd10, 12'h042, 12'h000);
    op(1'b0, 1'b0, 4'd9, 12'h000, 12'h999);
    op(1'b1, 1'b0, 4'd10, 12'h000, 12'h042);
    chk("iso_core_data", core_data_o, 12'h999);
    chk("iso_dbg_data", dbg_data_o, 12'h042);

    // Debug gating: pending while running, served once halted
    halted_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 4'd4;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("gate_no_rdy", dbg_rdy_o, 0);
    end
    halted_i = 1'b1;
    got = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) halted_i = 1'b0;
      if (dbg_rdy_o && got < 0) begin got = k; dbg_req_i = 1'b0; end
    end
    chk("gate_latency", got, 2);
    chk("gate_dbg_data", dbg_data_o, 12'h104);
    dbg_req_i = 1'b0;
    halted_i = 1'b1;

    // Reset in the middle of a sweep, at counter 7
    clr_req_i = 1'b1;
    tick();
    clr_req_i = 1'b0;
    for (int t = 2; t <= 8; t++) tick();
    chk("swp7_addr", ram_addr_o, 7);
    chk("swp7_busy", clr_busy_o, 1);
    Rst_n = 1'b0;
    #1;
    chk("arst_cs", ram_cs_o, 0);
    chk("arst_we", ram_we_o, 0);
    chk("arst_addr", ram_addr_o, 0);
    chk("arst_busy", clr_busy_o, 0);
    chk("arst_core_data", core_data_o, 0);
    chk("arst_dbg_data", dbg_data_o, 0);
    tick();
    tick();
    chk("part_mem0", mem[0], 12'h000);
    chk("part_mem6", mem[6], 12'h000);
    chk("part_mem7", mem[7], 12'h107);
    chk("part_mem9", mem[9], 12'h999);
    chk("part_mem15", mem[15], 12'h10F);
    Rst_n = 1'b1;
    op(1'b0, 1'b0, 4'd9, 12'h000, 12'h999);

    // Full sweep with a core read waiting and a stray clear pulse during it
    clr_req_i = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 1) begin
        clr_req_i = 1'b0; core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 4'd9;
      end
      if (t == 5) clr_req_i = 1'b1;
      if (t == 6) clr_req_i = 1'b0;
      chk("swp_busy", clr_busy_o, (t <= 16));
      chk("swp_core_rdy", core_rdy_o, (t == 19));
      if (t <= 16) chk("swp_addr", ram_addr_o, t - 1);
      if (t == 19) core_req_i = 1'b0;
    end
    chk("swp_core_data", core_data_o, 12'h000);
    nz = 0;
    for (int i = 0; i < ROWS; i++) if (mem[i] != 12'h000) nz++;
    chk("swp_mem_zero", nz, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
